maxnet_controller: RTL and testbench

//  FSM that sequences the 4-neuron Maxnet datapath: loads initial activations and epsilon,

---
 rtl/maxnet_controller.sv | 132 +++++++++++++
 tb/tb_maxnet_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// Sequencer for the 4-neuron Maxnet datapath: load, iterate PLU passes until convergence, return winner.
// Optional iteration limit enabled by defining MAXNET_TIMEOUT_EN.
module maxnet_controller #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic              plu_done,
    input  logic              loop,
    input  logic              finish,
    input  logic [31:0]       dp_out,
    output logic              rst_plu,
    output logic              start,
    output logic              eps_reg_we,
    output logic              we_a_reg,
    output logic              we_prim,
    output logic              mux_sel,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic [ITER_W-1:0] iter_count
`ifdef MAXNET_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    // state   | meaning
    // IDLE    | waiting for go
    // LOAD    | copy init activations and epsilon into the datapath
    // PRST    | reset the PLUs
    // PSTART  | start a PLU pass
    // PWAIT   | wait for all PLUs to finish
    // EVAL    | converged -> FWAIT, else write back and run another pass
    // FWAIT   | wait for output-check valid, capture winner
    // DONE    | completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PRST, S_PSTART, S_PWAIT, S_EVAL, S_FWAIT, S_DONE
    } state_t;

    localparam logic [ITER_W-1:0] ITER_SAT = '1;
`ifdef MAXNET_TIMEOUT_EN
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER - 1);
`endif

    state_t state;
    logic   write_back;

    // Abort wins over the write-back too, so an aborted EVAL leaves the datapath untouched.
    assign write_back = (state == S_EVAL) && !loop && !abort;

    always_comb begin
        rst_plu    = 1'b0;
        start      = 1'b0;
        eps_reg_we = 1'b0;
        we_a_reg   = 1'b0;
        we_prim    = 1'b0;
        mux_sel    = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        case (state)
            S_LOAD: begin
                mux_sel    = 1'b1;
                we_a_reg   = 1'b1;
                we_prim    = 1'b1;
                eps_reg_we = 1'b1;
            end
            S_PRST:   rst_plu  = 1'b1;
            S_PSTART: start    = 1'b1;
            S_EVAL:   we_a_reg = write_back;
            S_DONE:   done     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            result     <= '0;
            iter_count <= '0;
`ifdef MAXNET_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (go) state <= S_LOAD;
                S_LOAD: begin
                    iter_count <= '0;
                    result     <= '0;
`ifdef MAXNET_TIMEOUT_EN
                    timeout    <= 1'b0;
`endif
                    state      <= S_PRST;
                end
                S_PRST:   state <= S_PSTART;
                S_PSTART: state <= S_PWAIT;
                S_PWAIT:  if (plu_done) state <= S_EVAL;
                S_EVAL: begin
                    if (loop) begin
                        state <= S_FWAIT;
                    end else begin
                        if (iter_count != ITER_SAT) iter_count <= iter_count + 1'b1;
`ifdef MAXNET_TIMEOUT_EN
                        if (iter_count == ITER_LIMIT) begin
                            timeout <= 1'b1;
                            state   <= S_FWAIT;
                        end else begin
                            state   <= S_PRST;
                        end
`else
                        state <= S_PRST;
`endif
                    end
                end
                S_FWAIT: begin
                    if (finish) begin
                        result <= dp_out;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: vector table for a converging run plus hand sequences.
module tb_maxnet_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0, abort = 1'b0, plu_done = 1'b0, loop = 1'b0, finish = 1'b0;
    logic [31:0] dp_out = '0;
    logic        rst_plu, start, eps_reg_we, we_a_reg, we_prim, mux_sel, busy, done;
    logic [31:0] result;
    logic [7:0]  iter_count;
`ifdef MAXNET_TIMEOUT_EN
    logic        timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    maxnet_controller #(.ITER_W(8), .MAX_ITER(4)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .plu_done(plu_done),
        .loop(loop), .finish(finish), .dp_out(dp_out),
        .rst_plu(rst_plu), .start(start), .eps_reg_we(eps_reg_we), .we_a_reg(we_a_reg),
        .we_prim(we_prim), .mux_sel(mux_sel), .busy(busy), .done(done),
        .result(result), .iter_count(iter_count)
`ifdef MAXNET_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    // {rst_plu, start, eps_reg_we, we_a_reg, we_prim, mux_sel, busy, done}
    logic [7:0] ctrl;
    assign ctrl = {rst_plu, start, eps_reg_we, we_a_reg, we_prim, mux_sel, busy, done};

    localparam logic [7:0] C_IDLE   = 8'h00;
    localparam logic [7:0] C_LOAD   = 8'h3E;
    localparam logic [7:0] C_PRST   = 8'h82;
    localparam logic [7:0] C_PSTART = 8'h42;
    localparam logic [7:0] C_WAIT   = 8'h02;
    localparam logic [7:0] C_WB     = 8'h12;
    localparam logic [7:0] C_DONE   = 8'h03;

    typedef struct {
        logic        go, pd, lp, fin;
        logic [31:0] dout;
        logic [7:0]  ctrl;
        logic [7:0]  iter;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic g, pd, lp, fin, input logic [31:0] d,
                                input logic [7:0] c, input logic [7:0] it, input logic [31:0] r);
        vec_t v;
        v.go = g; v.pd = pd; v.lp = lp; v.fin = fin; v.dout = d;
        v.ctrl = c; v.iter = it; v.res = r;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after the falling edge, leave 1 time unit for outputs to settle.
    task automatic cyc(input logic g, pd, lp, fin, ab, input logic [31:0] d);
        @(negedge clk);
        go = g; plu_done = pd; loop = lp; finish = fin; abort = ab; dp_out = d;
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
        chk("reset_iter", 32'(iter_count), 32'd0);
        chk("reset_result", result, 32'd0);
`ifdef MAXNET_TIMEOUT_EN
        chk("reset_timeout", 32'(timeout), 32'd0);
`endif
        rst_n = 1'b1;

        // converging run: three passes, loop at the 3rd EVAL, go pulsed while busy
        add(1, 0, 0, 0, 0, C_IDLE, 0, 0);
        add(0, 0, 0, 0, 0, C_LOAD, 0, 0);
        for (int p = 0; p < 3; p++) begin
            add(0, 0, 0, 0, 0, C_PRST, 8'(p), 0);
            add(0, 0, 0, 0, 0, C_PSTART, 8'(p), 0);
            for (int k = 1; k <= 5; k++)
                add(k == 2, k == 5, 0, 0, 0, C_WAIT, 8'(p), 0);
            add(1, 0, p == 2, 0, 0, (p == 2) ? C_WAIT : C_WB, 8'(p), 0);
        end
        add(0, 0, 0, 0, 0, C_WAIT, 2, 0);
        add(0, 0, 0, 1, 32'h3F000000, C_WAIT, 2, 0);
        add(0, 0, 0, 0, 0, C_DONE, 2, 32'h3F000000);
        add(0, 0, 0, 0, 0, C_IDLE, 2, 32'h3F000000);
        add(0, 0, 0, 0, 0, C_IDLE, 2, 32'h3F000000);

        foreach (vecs[i]) begin
            cyc(vecs[i].go, vecs[i].pd, vecs[i].lp, vecs[i].fin, 1'b0, vecs[i].dout);
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("vec%0d_iter", i), 32'(iter_count), 32'(vecs[i].iter));
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
        end

        // go held high: immediate convergence, then relaunch right after DONE
        cyc(1, 0, 0, 0, 0, 0);              // IDLE
        cyc(1, 0, 0, 0, 0, 0);              // LOAD
        chk("hold_load", 32'(ctrl), 32'(C_LOAD));
        cyc(1, 0, 0, 0, 0, 0);              // PRST
        cyc(1, 0, 0, 0, 0, 0);              // PSTART
        cyc(1, 1, 0, 0, 0, 0);              // PWAIT
        cyc(1, 0, 1, 0, 0, 0);              // EVAL, converged
        chk("hold_eval_nowb", 32'(ctrl), 32'(C_WAIT));
        cyc(1, 0, 0, 1, 0, 32'hA5A50001);   // FWAIT
        cyc(1, 0, 0, 0, 0, 0);              // DONE
        chk("hold_done", 32'(ctrl), 32'(C_DONE));
        chk("hold_result", result, 32'hA5A50001);
        chk("hold_iter", 32'(iter_count), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);              // IDLE
        chk("hold_idle", 32'(ctrl), 32'(C_IDLE));
        cyc(0, 0, 0, 0, 0, 0);              // relaunched LOAD
        chk("hold_relaunch", 32'(ctrl), 32'(C_LOAD));

        // abort in the same cycle as plu_done, loop and finish
        cyc(0, 0, 0, 0, 0, 0);              // PRST
        chk("abort_result_cleared", result, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);              // PSTART
        cyc(0, 1, 0, 0, 0, 0);              // PWAIT
        cyc(0, 0, 0, 0, 0, 0);              // EVAL write-back
        chk("abort_pre_wb", 32'(ctrl), 32'(C_WB));
        cyc(0, 0, 0, 0, 0, 0);              // PRST
        cyc(0, 0, 0, 0, 0, 0);              // PSTART
        cyc(0, 1, 1, 1, 1, 32'hDEADBEEF);   // PWAIT + abort
        cyc(0, 0, 1, 1, 0, 32'hDEADBEEF);
        chk("abort_idle", 32'(ctrl), 32'(C_IDLE));
        chk("abort_iter", 32'(iter_count), 32'd1);
        chk("abort_result", result, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("abort_no_done", 32'(ctrl), 32'(C_IDLE));

        // async reset in the middle of PWAIT
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);              // LOAD
        cyc(0, 0, 0, 0, 0, 0);              // PRST
        cyc(0, 0, 0, 0, 0, 0);              // PSTART
        cyc(0, 1, 0, 0, 0, 0);              // PWAIT
        cyc(0, 0, 0, 0, 0, 0);              // EVAL write-back
        cyc(0, 0, 0, 0, 0, 0);              // PRST
        cyc(0, 0, 0, 0, 0, 0);              // PSTART
        cyc(0, 0, 0, 0, 0, 0);              // PWAIT
        chk("rst_pre_wait", 32'(ctrl), 32'(C_WAIT));
        chk("rst_pre_iter", 32'(iter_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'(ctrl), 32'(C_IDLE));
        chk("rst_mid_iter", 32'(iter_count), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 0, 0, 0, 0);
        chk("rst_stay_idle", 32'(ctrl), 32'(C_IDLE));

`ifndef MAXNET_TIMEOUT_EN
        // saturation: 260 unconverged passes
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);              // LOAD
        for (int p = 0; p < 260; p++) begin
            cyc(0, 0, 0, 0, 0, 0);          // PRST
            cyc(0, 0, 0, 0, 0, 0);          // PSTART
            cyc(0, 1, 0, 0, 0, 0);          // PWAIT
            cyc(0, 0, 0, 0, 0, 0);          // EVAL
        end
        cyc(0, 0, 0, 0, 0, 0);              // PRST
        chk("sat_ctrl", 32'(ctrl), 32'(C_PRST));
        chk("sat_iter", 32'(iter_count), 32'd255);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("sat_abort_idle", 32'(ctrl), 32'(C_IDLE));
`else
        // iteration limit of 4 with loop held low
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);              // LOAD
        for (int p = 0; p < 4; p++) begin
            cyc(0, 0, 0, 0, 0, 0);          // PRST
            chk($sformatf("to_prst%0d", p), 32'(ctrl), 32'(C_PRST));
            chk($sformatf("to_flag%0d", p), 32'(timeout), 32'd0);
            cyc(0, 0, 0, 0, 0, 0);          // PSTART
            cyc(0, 1, 0, 0, 0, 0);          // PWAIT
            cyc(0, 0, 0, 0, 0, 0);          // EVAL
            chk($sformatf("to_wb%0d", p), 32'(ctrl), 32'(C_WB));
        end
        cyc(0, 0, 0, 0, 0, 0);              // FWAIT
        chk("to_fwait", 32'(ctrl), 32'(C_WAIT));
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_iter", 32'(iter_count), 32'd4);
        cyc(0, 0, 0, 1, 0, 32'h12345678);
        cyc(0, 0, 0, 0, 0, 0);              // DONE
        chk("to_done", 32'(ctrl), 32'(C_DONE));
        chk("to_result", result, 32'h12345678);
        cyc(1, 0, 0, 0, 0, 0);              // IDLE
        cyc(0, 0, 0, 0, 0, 0);              // LOAD
        chk("to_hold", 32'(timeout), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);              // PRST
        chk("to_cleared", 32'(timeout), 32'd0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
